// File: rtl/alu_exec_seq.sv
// rtl/alu_exec_seq.sv - execute-stage ALU: single-cycle ops plus an iterative one-bit-per-cycle SLL
// Operands are captured at accept, and the result is held in DONE until it is taken downstream.
module alu_exec_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [3:0]       alucontrol_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [SHW-1:0]   shamt_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             overflow_o,
  output logic             err_o,
  output logic             busy_o
);

  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b0011;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             overflow_q, overflow_d;
  logic             err_q, err_d;
  logic [SHW-1:0]   cnt_q, cnt_d;

  logic [WIDTH-1:0] sum, diff, alu_res, shifted;
  logic             alu_ovf, alu_err, slt_lt;

  assign sum     = a_i + b_i;
  assign diff    = a_i - b_i;
  assign slt_lt  = $signed(a_i) < $signed(b_i);
  assign shifted = {result_q[WIDTH-2:0], 1'b0};

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_err = 1'b0;
    case (alucontrol_i)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_AND:  alu_res = a_i & b_i;
      OP_OR:   alu_res = a_i | b_i;
      OP_NOR:  alu_res = ~(a_i | b_i);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt_lt};
      // Only reached with shamt=0 for the single-cycle path, so this is just b.
      OP_SLL:  alu_res = b_i << shamt_i;
      default: alu_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    zero_d     = zero_q;
    overflow_d = overflow_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          if (alucontrol_i == OP_SLL && shamt_i != '0) begin
            result_d   = b_i;
            cnt_d      = shamt_i;
            zero_d     = (b_i == '0);
            overflow_d = 1'b0;
            err_d      = 1'b0;
            state_d    = SHIFT;
          end else begin
            result_d   = alu_res;
            zero_d     = (alu_res == '0);
            overflow_d = alu_ovf;
            err_d      = alu_err;
            state_d    = DONE;
          end
        end
      end
      SHIFT: begin
        result_d = shifted;
        zero_d   = (shifted == '0);
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == SHW'(1)) state_d = DONE;
      end
      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      result_q   <= '0;
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      overflow_q <= overflow_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign busy_o      = (state_q != IDLE);
  assign result_o    = result_q;
  assign zero_o      = zero_q;
  assign overflow_o  = overflow_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_alu_exec_seq.sv
// tb/tb_alu_exec_seq.sv - scoreboard bench for alu_exec_seq with directed and random operations
module tb_alu_exec_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  alucontrol = 4'b0;
  logic [31:0] a = '0, b = '0;
  logic [4:0]  shamt = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero, overflow, err, busy;

  alu_exec_seq #(.WIDTH(32), .SHW(5)) dut (
    .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .alucontrol_i(alucontrol), .a_i(a), .b_i(b), .shamt_i(shamt),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .result_o(result),
    .zero_o(zero), .overflow_o(overflow), .err_o(err), .busy_o(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] r;
    logic        z, o, e;
    int          due;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0, n_errors = 0;
  int   cyc = 0;
  int   hold_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: signed arithmetic done in 64 bits, shift done in one step.
  function automatic exp_t model(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                                 input logic [4:0] sh);
    exp_t   m;
    longint sx, sy, s;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    m.r = '0; m.o = 1'b0; m.e = 1'b0; m.due = 0;
    case (c)
      4'b0010: begin s = sx + sy; m.r = x + y; m.o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'b0110: begin s = sx - sy; m.r = x - y; m.o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'b0000: m.r = x & y;
      4'b0001: m.r = x | y;
      4'b1100: m.r = ~(x | y);
      4'b0111: m.r = (sx < sy) ? 32'd1 : 32'd0;
      4'b0011: m.r = y << sh;
      default: m.e = 1'b1;
    endcase
    m.z = (m.r == 32'd0);
    return m;
  endfunction

  task automatic issue(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] sh, input bit push);
    int   guard;
    int   acc;
    exp_t m;
    @(posedge clk); #1;
    alucontrol = c; a = x; b = y; shamt = sh; in_valid = 1'b1;
    @(negedge clk);
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    acc = cyc;
    #1;
    in_valid = 1'b0;
    alucontrol = 4'($urandom); a = $urandom; b = $urandom; shamt = 5'($urandom);
    if (push) begin
      m = model(c, x, y, sh);
      m.due = acc + ((c == 4'b0011 && sh != 0) ? int'(sh) + 1 : 1);
      sbq.push_back(m);
    end
  endtask

  task automatic drain();
    int guard = 0;
    while (sbq.size() != 0 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) chk("drain_timeout", 32'(sbq.size()), 32'd0);
  endtask

  // Monitor: compares on the first valid cycle, then checks the held values until taken.
  bit          holding = 0, post_xfer = 0;
  logic [31:0] cap_r;
  logic        cap_z, cap_o, cap_e;
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (reset) begin
      holding   = 0;
      post_xfer = 0;
      out_ready = 1'b0;
    end else begin
      if (post_xfer) begin
        chk("in_ready_after_take", 32'(in_ready), 32'd1);
        chk("out_valid_after_take", 32'(out_valid), 32'd0);
        post_xfer = 0;
      end
      if (out_valid) begin
        if (!holding) begin
          if (sbq.size() == 0) begin
            chk("spurious_out_valid", 32'(out_valid), 32'd0);
          end else begin
            e = sbq[0];
            chk("latency", 32'(cyc), 32'(e.due));
            chk("result", result, e.r);
            chk("zero", 32'(zero), 32'(e.z));
            chk("overflow", 32'(overflow), 32'(e.o));
            chk("err", 32'(err), 32'(e.e));
            chk("busy_in_done", 32'({busy, in_ready}), 32'b10);
            cap_r = result; cap_z = zero; cap_o = overflow; cap_e = err;
            holding = 1;
          end
        end else begin
          chk("hold_result", result, cap_r);
          chk("hold_flags", 32'({zero, overflow, err}), 32'({cap_z, cap_o, cap_e}));
        end
        if (hold_cnt > 0) begin
          hold_cnt--;
          out_ready = 1'b0;
        end else begin
          out_ready = ($urandom_range(3) != 0);
        end
        if (out_ready && holding) begin
          void'(sbq.pop_front());
          holding   = 0;
          post_xfer = 1;
        end
      end else begin
        out_ready = 1'($urandom);
      end
    end
  end

  initial begin
    logic [3:0]  codes [11];
    logic [31:0] specials [4];
    logic [31:0] x, y;
    codes = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100, 4'b0111, 4'b0011, 4'b0011,
              4'b1010, 4'b1111, 4'b0101};
    specials = '{32'h0, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", 32'({zero, overflow, err, busy}), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    issue(4'b0010, 32'h7FFFFFFF, 32'd1, 5'd0, 1);
    hold_cnt = 3;
    issue(4'b0110, 32'd5, 32'd5, 5'd0, 1);
    issue(4'b0111, 32'h80000000, 32'd1, 5'd0, 1);
    issue(4'b1100, 32'd0, 32'd0, 5'd0, 1);
    issue(4'b0001, 32'hF0, 32'h0F, 5'd0, 1);
    issue(4'b0011, 32'd3, 32'd3, 5'd4, 1);
    issue(4'b0011, 32'd0, 32'h1234ABCD, 5'd0, 1);
    issue(4'b0011, 32'd0, 32'd1, 5'd31, 1);
    issue(4'b1010, 32'd9, 32'd9, 5'd0, 1);
    issue(4'b0010, 32'd2, 32'd3, 5'd0, 1);
    drain();

    // Reset in the middle of a long shift must discard the operation.
    issue(4'b0011, 32'd0, 32'h5, 5'd20, 0);
    repeat (6) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_result", result, 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    repeat (25) @(negedge clk);
    issue(4'b0010, 32'd100, 32'hFFFFFFFF, 5'd0, 1);
    drain();

    for (int i = 0; i < 150; i++) begin
      x = ($urandom_range(3) == 0) ? specials[$urandom_range(3)] : $urandom;
      y = ($urandom_range(3) == 0) ? specials[$urandom_range(3)] : $urandom;
      issue(codes[$urandom_range(10)], x, y, 5'($urandom), 1);
    end
    drain();
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
